// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory access unit and data memory.
// master = access unit, slave = memory.
interface mem_access_unit_if #(
   parameter int WIDTH = 32
);
   logic             MEM_REQ;
   logic             MEM_WE;
   logic [WIDTH-1:0] MEM_ADDR;
   logic [WIDTH-1:0] MEM_WDATA;
   logic             MEM_ACK;
   logic [WIDTH-1:0] MEM_RDATA;

   modport master (
      output MEM_REQ,
      output MEM_WE,
      output MEM_ADDR,
      output MEM_WDATA,
      input  MEM_ACK,
      input  MEM_RDATA
   );

   modport slave (
      input  MEM_REQ,
      input  MEM_WE,
      input  MEM_ADDR,
      input  MEM_WDATA,
      output MEM_ACK,
      output MEM_RDATA
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: issues one word access per instruction,
// stalls the pipeline until ack or timeout, flags misaligned addresses.
module mem_access_unit #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic             MEM_TO_REG_M,
   input  logic             MEM_WRITE_M,
   input  logic [WIDTH-1:0] ALU_OUT_M,
   input  logic [WIDTH-1:0] WRITE_DATA_M,
   output logic             STALL_M,
   output logic [WIDTH-1:0] READ_DATA_M,
   output logic             MISALIGN_M,
   output logic             TIMEOUT_M,
   mem_access_unit_if.master mem
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_cnt;
   logic             r_req;
   logic             r_we;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_rdata;
   logic             r_timeout;

   logic w_req;
   logic w_aligned;
   logic w_issue;
   logic w_ack;
   logic w_expire;
   logic w_stall;
   logic w_misalign;

   assign w_req     = MEM_TO_REG_M | MEM_WRITE_M;
   assign w_aligned = (ALU_OUT_M[1:0] == 2'b00);

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Ack is only looked at in BUSY; it beats the timeout in the last wait cycle.
   always_comb begin
      w_next     = r_state;
      w_stall    = 1'b0;
      w_misalign = 1'b0;
      w_issue    = 1'b0;
      w_ack      = 1'b0;
      w_expire   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_aligned) begin
                  w_stall = 1'b1;
                  w_issue = 1'b1;
                  w_next  = S_BUSY;
               end else begin
                  w_misalign = 1'b1;
               end
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (mem.MEM_ACK) begin
               w_ack  = 1'b1;
               w_next = S_DONE;
            end else if (r_cnt == LP_LAST) begin
               w_expire = 1'b1;
               w_next   = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_cnt     <= '0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_issue) begin
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= MEM_WRITE_M;
            r_addr  <= ALU_OUT_M;
            r_wdata <= WRITE_DATA_M;
         end
         if (w_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
               r_rdata <= mem.MEM_RDATA;
            end
         end
         if (w_expire) begin
            r_req <= 1'b0;
            if (!r_we) begin
               r_rdata <= '0;
            end
         end
         if ((r_state == S_BUSY) && !w_ack && !w_expire) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign STALL_M       = w_stall;
   assign MISALIGN_M    = w_misalign;
   assign TIMEOUT_M     = r_timeout;
   assign READ_DATA_M   = r_rdata;
   assign mem.MEM_REQ   = r_req;
   assign mem.MEM_WE    = r_we;
   assign mem.MEM_ADDR  = r_addr;
   assign mem.MEM_WDATA = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model checked every cycle
// plus directed accesses with hand-computed cycle counts and data.
module tb_mem_access_unit;

   localparam int W  = 32;
   localparam int TO = 16;

   logic         CLK;
   logic         CLR_N;
   logic         MEM_TO_REG_M;
   logic         MEM_WRITE_M;
   logic [W-1:0] ALU_OUT_M;
   logic [W-1:0] WRITE_DATA_M;
   logic         STALL_M;
   logic [W-1:0] READ_DATA_M;
   logic         MISALIGN_M;
   logic         TIMEOUT_M;

   mem_access_unit_if #(.WIDTH(W)) mif ();

   mem_access_unit #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .CLK          (CLK),
      .CLR_N        (CLR_N),
      .MEM_TO_REG_M (MEM_TO_REG_M),
      .MEM_WRITE_M  (MEM_WRITE_M),
      .ALU_OUT_M    (ALU_OUT_M),
      .WRITE_DATA_M (WRITE_DATA_M),
      .STALL_M      (STALL_M),
      .READ_DATA_M  (READ_DATA_M),
      .MISALIGN_M   (MISALIGN_M),
      .TIMEOUT_M    (TIMEOUT_M),
      .mem          (mif)
   );

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: one outstanding access, counted in elapsed BUSY cycles (1..TO).
   bit         m_busy, m_done, m_to, m_req, m_we;
   int         m_wait;
   logic [W-1:0] m_rd, m_addr, m_wd;

   always @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         m_busy <= 0; m_done <= 0; m_to <= 0; m_req <= 0; m_we <= 0;
         m_wait <= 0; m_rd <= '0; m_addr <= '0; m_wd <= '0;
      end else begin
         m_to <= 0;
         if (m_busy) begin
            if (mif.MEM_ACK) begin
               m_busy <= 0; m_done <= 1; m_req <= 0;
               if (!m_we) m_rd <= mif.MEM_RDATA;
            end else if (m_wait == TO) begin
               m_busy <= 0; m_done <= 1; m_req <= 0; m_to <= 1;
               if (!m_we) m_rd <= '0;
            end else begin
               m_wait <= m_wait + 1;
            end
         end else if (m_done) begin
            m_done <= 0;
         end else if ((MEM_TO_REG_M || MEM_WRITE_M) && ALU_OUT_M[1:0] == 2'b00) begin
            m_busy <= 1; m_wait <= 1; m_req <= 1;
            m_we <= MEM_WRITE_M; m_addr <= ALU_OUT_M; m_wd <= WRITE_DATA_M;
         end
      end
   end

   always @(negedge CLK) begin
      bit idle_req, al;
      if (chk_on && CLR_N) begin
         idle_req = !m_busy && !m_done && (MEM_TO_REG_M || MEM_WRITE_M);
         al = (ALU_OUT_M[1:0] == 2'b00);
         check("stall", W'(STALL_M), W'(m_busy || (idle_req && al)));
         check("misalign", W'(MISALIGN_M), W'(idle_req && !al));
         check("timeout", W'(TIMEOUT_M), W'(m_to));
         check("rdata", READ_DATA_M, m_rd);
         check("mem_req", W'(mif.MEM_REQ), W'(m_req));
         if (m_req) begin
            check("mem_we", W'(mif.MEM_WE), W'(m_we));
            check("mem_addr", mif.MEM_ADDR, m_addr);
            check("mem_wdata", mif.MEM_WDATA, m_wd);
         end
      end
   end

   logic         cap_we, cap_mis;
   logic [W-1:0] cap_addr, cap_wd;

   // ackc: BUSY cycle (1-based) in which MEM_ACK pulses; 0 = never.
   task automatic access(input bit ld, input bit st, input logic [W-1:0] a,
                         input logic [W-1:0] wd, input int ackc,
                         input logic [W-1:0] rd,
                         output int nst, output int nreq, output int nto);
      bit fin = 0;
      nst = 0; nreq = 0; nto = 0;
      @(posedge CLK); #1;
      MEM_TO_REG_M = ld; MEM_WRITE_M = st; ALU_OUT_M = a; WRITE_DATA_M = wd;
      mif.MEM_RDATA = rd;
      for (int c = 0; c < 40; c++) begin
         mif.MEM_ACK = (ackc > 0 && c == ackc);
         @(negedge CLK);
         if (c == 0) cap_mis = MISALIGN_M;
         if (c == 1) begin
            cap_we = mif.MEM_WE; cap_addr = mif.MEM_ADDR; cap_wd = mif.MEM_WDATA;
         end
         if (STALL_M) nst++;
         if (mif.MEM_REQ) nreq++;
         if (TIMEOUT_M) nto++;
         if (!STALL_M) begin
            fin = 1;
            break;
         end
         @(posedge CLK); #1;
      end
      if (!fin) check("access_bound", 0, 1);
      @(posedge CLK); #1;
      MEM_TO_REG_M = 0; MEM_WRITE_M = 0; ALU_OUT_M = '0; WRITE_DATA_M = '0;
      mif.MEM_ACK = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=hang want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nst, nreq, nto;
      CLR_N = 0; MEM_TO_REG_M = 0; MEM_WRITE_M = 0;
      ALU_OUT_M = '0; WRITE_DATA_M = '0;
      mif.MEM_ACK = 0; mif.MEM_RDATA = '0;
      cap_we = 0; cap_mis = 0; cap_addr = '0; cap_wd = '0;
      #23;
      check("rst_req", W'(mif.MEM_REQ), 0);
      check("rst_we", W'(mif.MEM_WE), 0);
      check("rst_addr", mif.MEM_ADDR, 0);
      check("rst_wdata", mif.MEM_WDATA, 0);
      check("rst_rdata", READ_DATA_M, 0);
      check("rst_to", W'(TIMEOUT_M), 0);
      check("rst_stall", W'(STALL_M), 0);
      @(posedge CLK); #1;
      CLR_N = 1; chk_on = 1;

      access(1, 0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, nst, nreq, nto);
      check("ld_stall_cyc", nst, 4);
      check("ld_req_cyc", nreq, 3);
      check("ld_addr", cap_addr, 32'h10);
      check("ld_we", W'(cap_we), 0);
      check("ld_data", READ_DATA_M, 32'hDEAD_BEEF);

      access(0, 1, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_0000, nst, nreq, nto);
      check("st_stall_cyc", nst, 2);
      check("st_we", W'(cap_we), 1);
      check("st_addr", cap_addr, 32'h20);
      check("st_wdata", cap_wd, 32'h1234_5678);
      check("st_rdata_keep", READ_DATA_M, 32'hDEAD_BEEF);

      access(1, 0, 32'h0000_0013, 32'h0, 1, 32'h0, nst, nreq, nto);
      check("mis_flag", W'(cap_mis), 1);
      check("mis_stall_cyc", nst, 0);
      check("mis_req_cyc", nreq, 0);

      access(1, 0, 32'h0000_0044, 32'h0, 0, 32'h0, nst, nreq, nto);
      check("to_req_cyc", nreq, 16);
      check("to_stall_cyc", nst, 17);
      check("to_pulse", nto, 1);
      check("to_rdata", READ_DATA_M, 0);

      access(1, 1, 32'h0000_0048, 32'h0BAD_CAFE, 2, 32'h0, nst, nreq, nto);
      check("both_we", W'(cap_we), 1);
      check("both_wdata", cap_wd, 32'h0BAD_CAFE);
      check("both_stall_cyc", nst, 3);

      access(1, 0, 32'h0000_004C, 32'h0, 16, 32'hA5A5_0001, nst, nreq, nto);
      check("late_ack_to", nto, 0);
      check("late_ack_stall", nst, 17);
      check("late_ack_data", READ_DATA_M, 32'hA5A5_0001);

      access(0, 1, 32'h0000_0050, 32'h7, 0, 32'h0, nst, nreq, nto);
      check("st_to_pulse", nto, 1);
      check("st_to_rdata", READ_DATA_M, 32'hA5A5_0001);

      @(posedge CLK); #1;
      mif.MEM_ACK = 1; mif.MEM_RDATA = 32'h5555_5555;
      @(posedge CLK); #1;
      mif.MEM_ACK = 0;
      @(negedge CLK);
      check("idle_ack_ign", READ_DATA_M, 32'hA5A5_0001);

      @(posedge CLK); #1;
      MEM_TO_REG_M = 1; ALU_OUT_M = 32'h80;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      @(negedge CLK); #2;
      CLR_N = 0; MEM_TO_REG_M = 0; ALU_OUT_M = '0;
      #1;
      check("mid_rst_req", W'(mif.MEM_REQ), 0);
      check("mid_rst_addr", mif.MEM_ADDR, 0);
      check("mid_rst_rdata", READ_DATA_M, 0);
      check("mid_rst_stall", W'(STALL_M), 0);
      @(posedge CLK); #1;
      CLR_N = 1;
      mif.MEM_ACK = 1; mif.MEM_RDATA = 32'hCAFE_F00D;
      @(posedge CLK); #1;
      mif.MEM_ACK = 0;
      @(negedge CLK);
      check("post_rst_rdata", READ_DATA_M, 0);
      check("post_rst_req", W'(mif.MEM_REQ), 0);
      check("post_rst_stall", W'(STALL_M), 0);

      @(posedge CLK); #1;
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WIDTH, default 32, data/address width.
REQ-002 Parameter TIMEOUT, default 16, maximum wait cycles for MEM_ACK (range 2..255).
REQ-003 CLK  input  1  single clock, rising-edge active.
REQ-004 CLR_N  input  1  asynchronous active-low reset.
REQ-005 MEM_TO_REG_M  input  1  load request from EX/MEM register.
REQ-006 MEM_WRITE_M  input  1  store request from EX/MEM register.
REQ-007 ALU_OUT_M  input  WIDTH  byte address of access.
REQ-008 WRITE_DATA_M  input  WIDTH  store data.
REQ-009 STALL_M  output  1  freeze upstream pipeline registers while high.
REQ-010 READ_DATA_M  output  WIDTH  load result, registered.
REQ-011 MISALIGN_M  output  1  one-cycle flag, address not word-aligned.
REQ-012 TIMEOUT_M  output  1  one-cycle flag, memory did not acknowledge.
REQ-013 MEM_REQ  output  1  request to data memory, registered.
REQ-014 MEM_WE  output  1  write enable to data memory, registered.
REQ-015 MEM_ADDR  output  WIDTH  registered address to memory.
REQ-016 MEM_WDATA  output  WIDTH  registered write data to memory.
REQ-017 MEM_ACK  input  1  one-cycle memory completion pulse.
REQ-018 MEM_RDATA  input  WIDTH  read data, valid with MEM_ACK.

Function
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 Request present = MEM_TO_REG_M or MEM_WRITE_M; if both high, access SHALL be a write.
REQ-021 IDLE, request present, ALU_OUT_M[1:0]==0: next state BUSY; MEM_REQ=1, MEM_WE=MEM_WRITE_M, MEM_ADDR=ALU_OUT_M, MEM_WDATA=WRITE_DATA_M latched at that edge.
REQ-022 IDLE, request present, ALU_OUT_M[1:0]!=0: no memory request, MISALIGN_M=1 that cycle (combinational), STALL_M=0, remain IDLE.
REQ-023 STALL_M SHALL be combinational: 1 in IDLE with aligned request present, 1 in BUSY, 0 in DONE.
REQ-024 BUSY: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA SHALL hold stable until MEM_ACK or timeout.
REQ-025 BUSY with MEM_ACK=1: MEM_REQ cleared; on read, READ_DATA_M<=MEM_RDATA; on write, READ_DATA_M unchanged; next state DONE.
REQ-026 Wait counter SHALL reset to 0 on entry to BUSY, increment each BUSY cycle without MEM_ACK; at count TIMEOUT-1 without ack: MEM_REQ cleared, TIMEOUT_M=1 for exactly one cycle (registered, during DONE), READ_DATA_M<=0 on read, next state DONE.
REQ-027 MEM_ACK in the timeout cycle SHALL win: normal completion, no TIMEOUT_M.
REQ-028 DONE SHALL last exactly one cycle, then IDLE; the pipeline advances during DONE so the same instruction is never reissued.
REQ-029 MEM_ACK outside BUSY SHALL be ignored.
REQ-030 Minimum latency aligned access with immediate ack: request cycle, BUSY 1 cycle, DONE 1 cycle -> STALL_M high 2 cycles.

Reset
REQ-031 CLR_N low SHALL immediately force state IDLE, counter 0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, READ_DATA_M=0, TIMEOUT_M=0, independent of CLK.
REQ-032 Reset during BUSY SHALL abandon the access; a later MEM_ACK SHALL be ignored.
REQ-033 After CLR_N rises, first request SHALL be accepted on the next rising CLK edge.

Verification
REQ-034 Load addr 0x0000_0010, MEM_ACK after 3 cycles with MEM_RDATA=0xDEAD_BEEF -> READ_DATA_M=0xDEAD_BEEF, STALL_M high 4 cycles.
REQ-035 Store addr 0x0000_0020 data 0x1234_5678, immediate ack -> MEM_WE=1, MEM_ADDR/MEM_WDATA match, STALL_M high 2 cycles, READ_DATA_M unchanged.
REQ-036 Load addr 0x0000_0013 -> MISALIGN_M=1 one cycle, MEM_REQ stays 0, STALL_M=0.
REQ-037 Load, no ack, TIMEOUT=16 -> MEM_REQ drops after 16 BUSY cycles, TIMEOUT_M one-cycle pulse, READ_DATA_M=0.
REQ-038 MEM_TO_REG_M and MEM_WRITE_M both 1 -> MEM_WE=1 (write issued).
REQ-039 CLR_N low mid-BUSY then late MEM_ACK -> all outputs 0, state IDLE, ack ignored.
